lcd_bus_arbiter: RTL and testbench
==================================

Name: lcd_bus_arbiter

Overview:
- Owns the character-LCD bus (E/RS/RW/DATA) and shares it between two byte-level requesters, e.g. a static-text writer and a live-value writer.
- Runs the power-on init sequence (function set, display on, entry mode, clear) itself before granting any requester.
- Produces the E strobe with setup, pulse and hold timing plus per-command execution delays, so requesters deal only in (RS, byte) transfers over a req/ack handshake.

Parameters:
T_POWERON, 20000, cycles after reset before the first init command
T_SETUP, 2, cycles RS/DATA stable with E=0 before E rises
T_PULSE, 10, cycles E=1
T_HOLD, 2, cycles RS/DATA held with E=0 after E falls
T_CMD, 2000, execution wait after a normal command or data byte
T_CLR, 80000, execution wait after clear/home (RS=0, DATA[7:1]==7'b0000001 or DATA==8'h01)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
req0  in  1  requester 0 transfer request
rs0  in  1  requester 0 RS (0=command, 1=data)
data0  in  8  requester 0 byte
ack0  out  1  one-cycle grant/consume pulse for requester 0
req1  in  1  requester 1 transfer request
rs1  in  1  requester 1 RS
data1  in  8  requester 1 byte
ack1  out  1  one-cycle grant/consume pulse for requester 1
busy  out  1  high unless in IDLE with init_done=1
init_done  out  1  high once the init sequence has completed
LCD_E  out  1  enable strobe
LCD_RS  out  1  register select
LCD_RW  out  1  read/write; always 0 (write-only)
LCD_DATA  out  8  data bus

Behaviour:
- Reset (rst=0, asynchronous):
  - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00.
  - ack0=ack1=0, busy=1, init_done=0.
  - State=PWR, counter=0, last_grant=1 (so requester 0 wins the first tie).
- Reset asserted mid-transfer aborts immediately: E drops the same instant, and init restarts from PWR after release.
- States: PWR, INIT, IDLE, SETUP, PULSE, HOLD, EXEC. All registered.
- PWR: count T_POWERON cycles, then enter INIT with init index 0.
- INIT: load RS=0 and DATA = init table [0x38, 0x0C, 0x06, 0x01] at the index, then go to SETUP. After EXEC for index 3, set init_done=1 and go to IDLE.
- IDLE:
  - Samples req0/req1 only when init_done=1.
  - One request high: grant it.
  - Both high: grant the requester not equal to last_grant.
  - On grant: latch rsN/dataN into LCD_RS/LCD_DATA, pulse ackN=1 for exactly the next cycle, update last_grant, go to SETUP.
  - No request: stay; bus outputs keep their last values with E=0.
- Handshake:
  - The requester holds req/rs/data stable until it sees ack.
  - The ack cycle consumes the byte. The requester drops req, or presents the next byte, on the cycle ack is high.
  - A req still high when IDLE is next reached is treated as a new byte.
- SETUP: E=0 for T_SETUP cycles, then PULSE.
- PULSE: E=1 for T_PULSE cycles, then HOLD.
- HOLD: E=0 for T_HOLD cycles, RS/DATA unchanged, then EXEC.
- EXEC: E=0. Wait T_CLR if the latched byte is clear/home (RS=0 and DATA is 0x01, 0x02 or 0x03), else T_CMD. Then return to INIT (during init) or IDLE.
- Cycle counts: each phase lasts exactly its parameter in cycles. A granted transfer occupies T_SETUP+T_PULSE+T_HOLD+T_exec cycles after the grant edge, then IDLE for at least 1 cycle.
- Counter width is wide enough for max(T_POWERON, T_CLR). Counter reloads to 0 on every state change.
- Requests during PWR/INIT/any non-IDLE state are ignored (no ack). They are not lost; the requester keeps holding.
- busy: 0 only in IDLE with init_done=1.
- LCD_RW is constant 0.
- ack0 and ack1 are never high in the same cycle.

Test Plan:
- Sim params (5,2,4,2,8,20). Release reset, no requests -> E pulses exactly 4 times with DATA 0x38,0x0C,0x06,0x01, RS=0. Each E-high lasts 4 cycles. Gap after 0x01 is 20 cycles. Then init_done=1, busy=0.
- req0 with rs0=1, data0=0x41 held high during init -> no ack until init_done. Then ack0 pulses one cycle, and E pulses with RS=1, DATA=0x41 after 2 setup cycles.
- req0 and req1 both held continuously (bytes 0x30 and 0x31) -> grants alternate 0,1,0,1 starting with requester 0. ack0/ack1 never overlap.
- Requester 1 sends RS=0, 0x01 -> post-HOLD wait is 20 cycles. RS=1, 0x01 -> wait is 8 cycles.
- Assert rst during PULSE of a data byte -> LCD_E=0 immediately. After release, the full init sequence repeats and the aborted byte is not re-sent unless its requester re-requests.
- Across all tests: LCD_RW is always 0, and RS/DATA never change while E=1 or during HOLD.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
`timescale 1ns/1ps
// lcd_bus_arbiter: owns the character-LCD write bus, runs the power-on init
// sequence, then shares the bus between two byte requesters over req/ack.
// Every E strobe is framed by setup/pulse/hold phases plus an execution wait.
module lcd_bus_arbiter #(
  parameter int unsigned T_POWERON = 20000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 10,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLR     = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic       init_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned T_MAX0 = (T_POWERON > T_CLR) ? T_POWERON : T_CLR;
  localparam int unsigned T_MAX  = (T_MAX0 > T_CMD) ? T_MAX0 : T_CMD;
  localparam int unsigned CNT_W  = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_PWR,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       init_idx;
  logic             last_grant;

  logic             grant0_c;
  logic             grant1_c;
  logic             is_clear_c;
  logic             exec_last_c;

  // Init table: 8-bit/2-line function set, display on, entry mode, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // The bus is write-only.
  assign LCD_RW = 1'b0;

  // Round-robin pick: a lone request wins, a tie goes away from last_grant.
  always_comb begin
    grant0_c = init_done && req0 && (!req1 || last_grant);
    grant1_c = init_done && req1 && (!req0 || !last_grant);
  end

  // Clear/home (0x01..0x03 as a command) needs the long execution wait.
  always_comb begin
    is_clear_c  = !LCD_RS && (LCD_DATA[7:2] == 6'b0) && (LCD_DATA[1:0] != 2'b00);
    exec_last_c = is_clear_c ? (cnt == CNT_W'(T_CLR - 1))
                             : (cnt == CNT_W'(T_CMD - 1));
  end

  // Main sequencer: power-on wait, init table, arbitration and E timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_PWR;
      cnt        <= '0;
      init_idx   <= '0;
      init_done  <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b1;
      LCD_E      <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_DATA   <= 8'h00;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        S_PWR: begin
          if (cnt == CNT_W'(T_POWERON - 1)) begin
            state <= S_INIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_INIT: begin
          LCD_RS   <= 1'b0;
          LCD_DATA <= init_cmd(init_idx);
          state    <= S_SETUP;
          cnt      <= '0;
        end
        S_IDLE: begin
          if (grant0_c) begin
            LCD_RS     <= rs0;
            LCD_DATA   <= data0;
            ack0       <= 1'b1;
            last_grant <= 1'b0;
            busy       <= 1'b1;
            state      <= S_SETUP;
            cnt        <= '0;
          end else if (grant1_c) begin
            LCD_RS     <= rs1;
            LCD_DATA   <= data1;
            ack1       <= 1'b1;
            last_grant <= 1'b1;
            busy       <= 1'b1;
            state      <= S_SETUP;
            cnt        <= '0;
          end else begin
            busy <= !init_done;
          end
        end
        S_SETUP: begin
          if (cnt == CNT_W'(T_SETUP - 1)) begin
            LCD_E <= 1'b1;
            state <= S_PULSE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt == CNT_W'(T_PULSE - 1)) begin
            LCD_E <= 1'b0;
            state <= S_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt == CNT_W'(T_HOLD - 1)) begin
            state <= S_EXEC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (exec_last_c) begin
            cnt <= '0;
            if (init_done) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else if (init_idx == 2'd3) begin
              init_done <= 1'b1;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else begin
              init_idx <= init_idx + 2'd1;
              state    <= S_INIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_PWR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for lcd_bus_arbiter: stimulus pushes expected grants and
// E-strobe contents; a negedge monitor pops and compares as the DUT acts.
module tb_lcd_bus_arbiter;

  localparam int unsigned T_POWERON = 5;
  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_PULSE   = 4;
  localparam int unsigned T_HOLD    = 2;
  localparam int unsigned T_CMD     = 8;
  localparam int unsigned T_CLR     = 20;
  localparam int unsigned BUDGET    = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, rs0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic       req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       ack0, ack1, busy, init_done;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(
    .T_POWERON(T_POWERON), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
    .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .busy(busy), .init_done(init_done),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  typedef struct packed {
    logic        rs;
    logic [7:0]  data;
    logic [31:0] exec;
  } xfer_t;

  xfer_t       exp_xfer[$];
  int unsigned exp_ack[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic push_xfer(input logic rs, input logic [7:0] data, input int unsigned exec);
    xfer_t x;
    x.rs   = rs;
    x.data = data;
    x.exec = 32'(exec);
    exp_xfer.push_back(x);
  endtask

  task automatic push_init();
    push_xfer(1'b0, 8'h38, T_CMD);
    push_xfer(1'b0, 8'h0C, T_CMD);
    push_xfer(1'b0, 8'h06, T_CMD);
    push_xfer(1'b0, 8'h01, T_CLR);
  endtask

  // Monitor state
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0, fall_cyc = 0, ack_cyc = 0, hold_left = 0;
  logic        e_prev = 1'b0, busy_prev = 1'b1;
  logic        ack_pend = 1'b0, gap_pend = 1'b0, stab_bad = 1'b0, rw_seen = 1'b0;
  logic [31:0] gap_exec = 32'd0;
  logic        lat_rs = 1'b0;
  logic [7:0]  lat_data = 8'h00;

  // Monitor: grants, strobe contents, strobe timing and bus stability.
  always @(negedge clk) begin : monitor
    xfer_t x;
    cyc++;
    if (LCD_RW !== 1'b0) rw_seen = 1'b1;
    if (!rst) begin
      e_prev    = 1'b0;
      busy_prev = 1'b1;
      ack_pend  = 1'b0;
      gap_pend  = 1'b0;
      hold_left = 0;
    end else begin
      if (ack0 || ack1) begin
        chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        chk("ack_after_init", 32'(init_done), 32'd1);
        if (exp_ack.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else chk("ack_id", 32'(ack1), 32'(exp_ack.pop_front()));
        ack_cyc  = cyc;
        ack_pend = 1'b1;
      end
      if (LCD_E && !e_prev) begin
        if (gap_pend) begin
          chk("init_gap", 32'(cyc - fall_cyc), 32'(T_HOLD + gap_exec + 1 + T_SETUP));
          gap_pend = 1'b0;
        end
        if (ack_pend) begin
          chk("setup_after_ack", 32'(cyc - ack_cyc), 32'(T_SETUP));
          ack_pend = 1'b0;
        end
        if (exp_xfer.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          x = exp_xfer.pop_front();
          chk("pulse_rs", 32'(LCD_RS), 32'(x.rs));
          chk("pulse_data", 32'(LCD_DATA), 32'(x.data));
          gap_exec = x.exec;
        end
        rise_cyc = cyc;
        lat_rs   = LCD_RS;
        lat_data = LCD_DATA;
        stab_bad = 1'b0;
      end else if (LCD_E) begin
        if (LCD_RS !== lat_rs || LCD_DATA !== lat_data) stab_bad = 1'b1;
      end else if (e_prev) begin
        chk("pulse_width", 32'(cyc - rise_cyc), 32'(T_PULSE));
        if (LCD_RS !== lat_rs || LCD_DATA !== lat_data) stab_bad = 1'b1;
        fall_cyc  = cyc;
        gap_pend  = 1'b1;
        hold_left = T_HOLD - 1;
        if (hold_left == 0) chk("stable_rs_data", 32'(stab_bad), 32'd0);
      end else if (hold_left > 0) begin
        if (LCD_RS !== lat_rs || LCD_DATA !== lat_data) stab_bad = 1'b1;
        hold_left--;
        if (hold_left == 0) chk("stable_rs_data", 32'(stab_bad), 32'd0);
      end
      if (!busy && busy_prev && gap_pend) begin
        chk("exec_wait", 32'(cyc - fall_cyc), 32'(T_HOLD + gap_exec));
        gap_pend = 1'b0;
      end
      e_prev    = LCD_E;
      busy_prev = busy;
    end
  end

  task automatic wait_ack(input int unsigned id);
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if ((id == 0 && ack0) || (id == 1 && ack1)) return;
    end
    chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_e_high();
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (LCD_E) return;
    end
    chk("e_timeout", 32'd0, 32'd1);
  endtask

  task automatic send1(input logic rs, input logic [7:0] data, input int unsigned exec);
    exp_ack.push_back(1);
    push_xfer(rs, data, exec);
    rs1 = rs; data1 = data; req1 = 1'b1;
    wait_ack(1);
    req1 = 1'b0;
    wait_idle();
  endtask

  initial begin : stim
    int unsigned n_acks;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_e", 32'(LCD_E), 32'd0);
    chk("rst_rs", 32'(LCD_RS), 32'd0);
    chk("rst_rw", 32'(LCD_RW), 32'd0);
    chk("rst_data", 32'(LCD_DATA), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);

    // Init sequence with requester 0 already waiting.
    push_init();
    exp_ack.push_back(0);
    push_xfer(1'b1, 8'h41, T_CMD);
    rs0 = 1'b1; data0 = 8'h41; req0 = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    wait_ack(0);
    req0 = 1'b0;
    wait_idle();

    // Clear command vs same byte as data.
    send1(1'b0, 8'h01, T_CLR);
    send1(1'b1, 8'h01, T_CMD);

    // Both requesters held: grants alternate starting with requester 0.
    for (int k = 0; k < 4; k++) begin
      exp_ack.push_back(k % 2);
      push_xfer(1'b1, (k % 2 == 0) ? 8'h30 : 8'h31, T_CMD);
    end
    rs0 = 1'b1; data0 = 8'h30; req0 = 1'b1;
    rs1 = 1'b1; data1 = 8'h31; req1 = 1'b1;
    n_acks = 0;
    for (int i = 0; i < 4 * BUDGET && n_acks < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) n_acks++;
    end
    chk("alt_ack_count", 32'(n_acks), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // Reset in the middle of a data strobe.
    exp_ack.push_back(0);
    push_xfer(1'b1, 8'h55, T_CMD);
    rs0 = 1'b1; data0 = 8'h55; req0 = 1'b1;
    wait_ack(0);
    req0 = 1'b0;
    wait_e_high();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_e", 32'(LCD_E), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_init_done", 32'(init_done), 32'd0);
    repeat (3) @(negedge clk);
    push_init();
    #1 rst = 1'b1;
    wait_idle();
    #1;
    chk("reinit_busy", 32'(busy), 32'd0);
    chk("reinit_done", 32'(init_done), 32'd1);
    repeat (60) @(negedge clk);

    chk("xfer_queue_empty", 32'(exp_xfer.size()), 32'd0);
    chk("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
    chk("rw_always_low", 32'(rw_seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
